// File: rtl/lock_input_conditioner.sv
// lock_input_conditioner
// Purpose : turns raw board switches/keys into clean, synchronized, debounced
//           active-high levels plus one-cycle rise/fall pulses for the lock FSM.
// Latency : a change held from before edge 0 shows on level/pulses at edge
//           DB_CYCLES+1 (2 synchronizer flops + DB_CYCLES debounce edges).
// Flow    : no backpressure; every input is conditioned independently each cycle.
//
// Ports:
//   clk        - system (divided) clock, rising-edge logic
//   reset      - asynchronous, active-high; clears all state and outputs
//   raw_in     - unsynchronized switch/key levels (polarity per ACTIVE_LOW_MASK)
//   level      - debounced, active-high-normalized level (registered)
//   rise_pulse - one-cycle pulse on accepted 0->1, plus auto-repeat pulses
//   fall_pulse - one-cycle pulse on accepted 1->0 (registered)
//
// Optional feature: define LOCK_INPUT_REPEAT_EN to build per-input auto-repeat
// for the REPEAT_MASK inputs. Without it, REPEAT_* parameters have no effect and
// every accepted press yields exactly one rise pulse.

module lock_input_conditioner #(
    parameter int                N_IN            = 6,
    parameter logic [N_IN-1:0]   ACTIVE_LOW_MASK = 6'b110000,
    parameter int                DB_CYCLES       = 3,
    parameter logic [N_IN-1:0]   REPEAT_MASK     = 6'b110000,
    parameter int                REPEAT_DELAY    = 8,
    parameter int                REPEAT_PERIOD   = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N_IN-1:0] raw_in,
    output logic [N_IN-1:0] level,
    output logic [N_IN-1:0] rise_pulse,
    output logic [N_IN-1:0] fall_pulse
);

    // ------------------------------------------------------------------
    // Elaboration-time parameter sanity
    // ------------------------------------------------------------------
    if (DB_CYCLES < 1 || DB_CYCLES > 15) begin : g_bad_db_cycles
        $error("lock_input_conditioner: DB_CYCLES must be in 1..15");
    end

    // Repeat timing only matters when at least one input is eligible.
    if (REPEAT_MASK != '0 && REPEAT_DELAY < 2) begin : g_bad_repeat_delay
        $error("lock_input_conditioner: REPEAT_DELAY must be >= 2");
    end

    if (REPEAT_MASK != '0 && REPEAT_PERIOD < 1) begin : g_bad_repeat_period
        $error("lock_input_conditioner: REPEAT_PERIOD must be >= 1");
    end

    // ------------------------------------------------------------------
    // Debounce counter sizing
    // ------------------------------------------------------------------
    localparam int              CW      = $clog2(DB_CYCLES + 1);
    localparam logic [CW-1:0]   DB_LAST = CW'(DB_CYCLES - 1);

    // ------------------------------------------------------------------
    // Normalize + two-flop synchronizer (whole vector at once)
    // ------------------------------------------------------------------
    logic [N_IN-1:0] s1;
    logic [N_IN-1:0] s2;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            // Inverting the active-low keys here means everything downstream
            // only ever deals with active-high levels.
            s1 <= raw_in ^ ACTIVE_LOW_MASK;
            s2 <= s1;
        end
    end

    // ------------------------------------------------------------------
    // Per-input debounce counters
    // ------------------------------------------------------------------
    // accept[i] is high on the edge where input i's level must toggle: the
    // synchronized value has disagreed with level for DB_CYCLES edges in a row.
    logic [N_IN-1:0] accept;

    for (genvar i = 0; i < N_IN; i++) begin : g_db
        logic [CW-1:0] cnt;

        assign accept[i] = (s2[i] != level[i]) && (cnt == DB_LAST);

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                cnt <= '0;
            end else if (s2[i] == level[i] || accept[i]) begin
                // Agreement (glitch over) or change just accepted: start over.
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Level and edge pulses, registered together so a pulse lines up with
    // the first cycle of the new level value.
    // ------------------------------------------------------------------
    logic [N_IN-1:0] rise_edge;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            level      <= '0;
            rise_edge  <= '0;
            fall_pulse <= '0;
        end else begin
            level      <= level ^ accept;
            rise_edge  <= accept & ~level;
            fall_pulse <= accept &  level;
        end
    end

`ifdef LOCK_INPUT_REPEAT_EN
    // ------------------------------------------------------------------
    // Auto-repeat: a held, eligible input re-issues rise pulses, first after
    // REPEAT_DELAY cycles, then every REPEAT_PERIOD cycles.
    // ------------------------------------------------------------------
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY
                                                            : REPEAT_PERIOD;
    localparam int            RW        = $clog2(RPT_MAX + 1);
    localparam logic [RW-1:0] RPT_DELAY = RW'(REPEAT_DELAY);
    localparam logic [RW-1:0] RPT_PER   = RW'(REPEAT_PERIOD);

    typedef enum logic [1:0] {
        RPT_IDLE   = 2'd0,
        RPT_DELAY_ST = 2'd1,
        RPT_REPEAT = 2'd2
    } rpt_state_t;

    logic [N_IN-1:0] rpt_fire;

    for (genvar i = 0; i < N_IN; i++) begin : g_rpt
        if (REPEAT_MASK[i]) begin : g_on
            rpt_state_t    state;
            logic [RW-1:0] rcnt;
            logic          rpt_q;

            // The counter holds "cycles since the last rise pulse"; it is
            // loaded with 1 on the edge that issues a pulse, so comparing it
            // against DELAY/PERIOD lands the next pulse exactly that many
            // edges later.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    state <= RPT_IDLE;
                    rcnt  <= '0;
                    rpt_q <= 1'b0;
                end else if (accept[i] && level[i]) begin
                    // Release accepted: drop out of repeat with no pulse,
                    // even if a repeat was due on this same edge.
                    state <= RPT_IDLE;
                    rcnt  <= '0;
                    rpt_q <= 1'b0;
                end else begin
                    rpt_q <= 1'b0;
                    case (state)
                        RPT_IDLE: begin
                            if (accept[i]) begin
                                state <= RPT_DELAY_ST;
                                rcnt  <= {{(RW-1){1'b0}}, 1'b1};
                            end
                        end
                        RPT_DELAY_ST: begin
                            if (rcnt == RPT_DELAY) begin
                                state <= RPT_REPEAT;
                                rcnt  <= {{(RW-1){1'b0}}, 1'b1};
                                rpt_q <= 1'b1;
                            end else begin
                                rcnt <= rcnt + 1'b1;
                            end
                        end
                        RPT_REPEAT: begin
                            if (rcnt == RPT_PER) begin
                                rcnt  <= {{(RW-1){1'b0}}, 1'b1};
                                rpt_q <= 1'b1;
                            end else begin
                                rcnt <= rcnt + 1'b1;
                            end
                        end
                        default: begin
                            state <= RPT_IDLE;
                            rcnt  <= '0;
                        end
                    endcase
                end
            end

            assign rpt_fire[i] = rpt_q;
        end else begin : g_off
            assign rpt_fire[i] = 1'b0;
        end
    end

    // Both terms are flop outputs; no path from raw_in reaches the port
    // without passing through registers.
    assign rise_pulse = rise_edge | rpt_fire;
`else
    assign rise_pulse = rise_edge;
`endif

endmodule
